slc3_button_ctrl: RTL



---
 rtl/slc3_button_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/slc3_button_ctrl.sv
// ---------------------------------------------------------------------------
// slc3_button_ctrl
// Front-panel conditioner for the SLC-3 Run/Continue pushbuttons.
//   - Synchronises each raw active-low button through SYNC_STAGES flops.
//   - Debounces each synchronised level (DEBOUNCE_CYCLES stable samples).
//   - Turns a Run+Continue chord into a held system reset (Reset_h). Once
//     asserted, Reset_h stays high for at least RESET_HOLD_CYCLES cycles.
//   - On release of a lone button, emits a one-cycle Run_p / Continue_p.
//     A release that ends a chord never pulses.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous active-high block reset
//   Run        in   raw Run button, active-low, asynchronous
//   Continue   in   raw Continue button, active-low, asynchronous
//   Reset_h    out  registered system reset to the core, active-high
//   Run_p      out  registered one-cycle Run pulse
//   Continue_p out  registered one-cycle Continue pulse
//   Btn_state  out  [2:0] registered FSM encoding for LED debug
//                   (only exists when SLC3_BTN_STATUS_EN is defined)
//
// Optional build macro: SLC3_BTN_STATUS_EN
// ---------------------------------------------------------------------------
module slc3_button_ctrl #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
`ifdef SLC3_BTN_STATUS_EN
    output logic [2:0] Btn_state,
`endif
    output logic       Reset_h,
    output logic       Run_p,
    output logic       Continue_p
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN_HELD  = 3'd1,
        S_CONT_HELD = 3'd2,
        S_RESET     = 3'd3,
        S_WAIT_REL  = 3'd4
    } state_t;

    // Saturating increment of the reset-hold counter.
    function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] h);
        if (h == HOLD_MAX) begin
            return h;
        end else begin
            return h + HOLD_ONE;
        end
    endfunction

    // Index 0 is Run, index 1 is Continue.
    logic [1:0]                  btn_raw_s;
    logic [1:0][SYNC_STAGES-1:0] sync_r;
    logic [1:0][CW-1:0]          db_cnt_r;
    logic [1:0]                  stable_r;
    logic                        run_pr_s;
    logic                        cont_pr_s;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [HW-1:0]   hold_r;
    logic [HW-1:0]   hold_nxt_s;
    logic            hold_done_s;
    logic            reset_h_r;
    logic            reset_h_nxt_s;
    logic            run_p_r;
    logic            run_p_nxt_s;
    logic            cont_p_r;
    logic            cont_p_nxt_s;

    assign btn_raw_s   = {Continue, Run};
    assign run_pr_s    = ~stable_r[0];
    assign cont_pr_s   = ~stable_r[1];
    assign hold_done_s = (hold_r == HOLD_MAX);

    // Synchroniser chains and debounce counters for both buttons.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]   <= {SYNC_STAGES{1'b1}};
                db_cnt_r[i] <= {CW{1'b0}};
            end
            stable_r <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], btn_raw_s[i]};
                // A level is accepted only after DEBOUNCE_CYCLES consecutive
                // samples disagree with the current debounced value.
                if (sync_r[i][SYNC_STAGES-1] == stable_r[i]) begin
                    db_cnt_r[i] <= {CW{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= sync_r[i][SYNC_STAGES-1];
                    db_cnt_r[i] <= {CW{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Next-state and pulse decode of the chord FSM.
    always_comb begin
        state_nxt_s  = state_r;
        run_p_nxt_s  = 1'b0;
        cont_p_nxt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run_pr_s && cont_pr_s) begin
                    state_nxt_s = S_RESET;
                end else if (run_pr_s) begin
                    state_nxt_s = S_RUN_HELD;
                end else if (cont_pr_s) begin
                    state_nxt_s = S_CONT_HELD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN_HELD: begin
                // The second button wins over a simultaneous release.
                if (cont_pr_s) begin
                    state_nxt_s = S_RESET;
                end else if (!run_pr_s) begin
                    state_nxt_s = S_IDLE;
                    run_p_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_RUN_HELD;
                end
            end
            S_CONT_HELD: begin
                if (run_pr_s) begin
                    state_nxt_s = S_RESET;
                end else if (!cont_pr_s) begin
                    state_nxt_s  = S_IDLE;
                    cont_p_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_CONT_HELD;
                end
            end
            S_RESET: begin
                if (!run_pr_s || !cont_pr_s) begin
                    state_nxt_s = S_WAIT_REL;
                end else begin
                    state_nxt_s = S_RESET;
                end
            end
            S_WAIT_REL: begin
                if (run_pr_s && cont_pr_s) begin
                    state_nxt_s = S_RESET;
                end else if (!run_pr_s && !cont_pr_s && hold_done_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_REL;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Hold counter and Reset_h decode. The counter only runs inside a chord,
    // so it is zero on every fresh entry into S_RESET and keeps counting
    // across a WAIT_REL -> RESET re-press.
    always_comb begin
        if ((state_r == S_RESET) || (state_r == S_WAIT_REL)) begin
            hold_nxt_s = hold_inc(hold_r);
        end else begin
            hold_nxt_s = {HW{1'b0}};
        end

        if (state_nxt_s == S_RESET) begin
            reset_h_nxt_s = 1'b1;
        end else if (state_nxt_s == S_WAIT_REL) begin
            reset_h_nxt_s = (hold_nxt_s != HOLD_MAX);
        end else begin
            reset_h_nxt_s = 1'b0;
        end
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= S_IDLE;
            hold_r    <= {HW{1'b0}};
            reset_h_r <= 1'b0;
            run_p_r   <= 1'b0;
            cont_p_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hold_r    <= hold_nxt_s;
            reset_h_r <= reset_h_nxt_s;
            run_p_r   <= run_p_nxt_s;
            cont_p_r  <= cont_p_nxt_s;
        end
    end

    assign Reset_h    = reset_h_r;
    assign Run_p      = run_p_r;
    assign Continue_p = cont_p_r;
`ifdef SLC3_BTN_STATUS_EN
    assign Btn_state  = state_r;
`endif

endmodule
